// File: rtl/fetch_pc.sv
// Fetch PC generator with one-entry output buffer, delayed branch
// redirect, misaligned-fetch fault capture and immediate flush.
module fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        flush,
  input  logic [31:0] flush_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_adel,
  input  logic        id_ready
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        vld_q, vld_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ins_q, ins_d;
  logic        adel_q, adel_d;
  logic        pv_q, pv_d;
  logic [31:0] pt_q, pt_d;

  logic slot_free;
  logic misal;
  logic fire;
  logic consume;

  assign slot_free = !vld_q || id_ready;
  assign misal     = pc_q[1:0] != 2'b00;
  assign consume   = vld_q && id_ready;
  assign imem_req  = (state_q == RUN) && slot_free
                     && !misal && !flush;
  assign fire      = imem_req && imem_ack;
  assign imem_addr = pc_q;
  assign if_valid  = vld_q;
  assign if_pc     = ipc_q;
  assign if_instr  = ins_q;
  assign if_adel   = adel_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    vld_d   = vld_q;
    ipc_d   = ipc_q;
    ins_d   = ins_q;
    adel_d  = adel_q;
    pv_d    = pv_q;
    pt_d    = pt_q;
    unique case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (consume) vld_d = 1'b0;
        if (slot_free && misal) begin
          vld_d   = 1'b1;
          ipc_d   = pc_q;
          ins_d   = 32'h0;
          adel_d  = 1'b1;
          state_d = FAULT;
        end else if (fire) begin
          vld_d  = 1'b1;
          ipc_d  = pc_q;
          ins_d  = imem_rdata;
          adel_d = 1'b0;
          pv_d   = 1'b0;
          if (redirect_valid) pc_d = redirect_target;
          else if (pv_q)      pc_d = pt_q;
          else                pc_d = pc_q + 32'd4;
        end
        // The delay slot is still to be fetched: park the target.
        if (redirect_valid && !fire) begin
          pv_d = 1'b1;
          pt_d = redirect_target;
        end
      end
      FAULT: begin
        if (consume) vld_d = 1'b0;
        if (redirect_valid) begin
          pc_d    = redirect_target;
          pv_d    = 1'b0;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush && state_q != IDLE) begin
      pc_d    = flush_target;
      vld_d   = 1'b0;
      adel_d  = 1'b0;
      pv_d    = 1'b0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      vld_q   <= 1'b0;
      ipc_q   <= 32'h0;
      ins_q   <= 32'h0;
      adel_q  <= 1'b0;
      pv_q    <= 1'b0;
      pt_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      ipc_q   <= ipc_d;
      ins_q   <= ins_d;
      adel_q  <= adel_d;
      pv_q    <= pv_d;
      pt_q    <= pt_d;
    end
  end

endmodule

// File: doc/fetch_pc.md
FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 redirect_valid  input  1  branch/jump resolved; asserted in the cycle its branch is accepted (if_valid && id_ready).
REQ-005 redirect_target  input  32  target from next-PC logic; it takes effect after the delay slot.
REQ-006 flush  input  1  immediate redirect with no delay slot (exception entry/return).
REQ-007 flush_target  input  32  address used when flush=1.
REQ-008 imem_req  output  1  fetch request to instruction memory.
REQ-009 imem_addr  output  32  fetch address.
REQ-010 imem_ack  input  1  same-cycle accept; imem_rdata is valid when imem_req && imem_ack.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 if_valid  output  1  output buffer holds an instruction.
REQ-013 if_pc, if_instr  output  32 each  buffered PC and instruction.
REQ-014 if_adel  output  1  buffered entry is a misaligned-fetch fault.
REQ-015 id_ready  input  1  decode consumes the buffer this cycle.

Function
REQ-016 The block SHALL have states IDLE, RUN and FAULT, a pc register, a 1-entry output buffer, and a pending redirect (pend_valid, pend_target).
REQ-017 IDLE SHALL move to RUN on the first clock edge after rst_n rises; no request is issued in IDLE.
REQ-018 "slot_free" = !if_valid || id_ready.
REQ-019 In RUN, imem_req = slot_free && pc[1:0]==0, and imem_addr SHALL equal pc at all times.
REQ-020 A fetch completes when imem_req && imem_ack. The buffer SHALL then load {pc, imem_rdata, adel=0} and if_valid=1 on the next edge (zero added latency).
REQ-021 On fetch completion, next pc SHALL be selected in this priority order:
- redirect_target if redirect_valid;
- else pend_target if pend_valid;
- else pc+4 (wraps modulo 2^32).
pend_valid SHALL then clear.
REQ-022 redirect_valid without a same-cycle completion SHALL latch pend_target and set pend_valid; a newer redirect SHALL overwrite an older pending one.
REQ-023 Consequence: exactly one delay-slot instruction (the fetch at branch+4) is delivered before the target.
REQ-024 A buffer consumed (if_valid && id_ready) with no same-cycle fill SHALL clear if_valid.
REQ-025 In RUN with pc[1:0]!=0 and slot_free, the block SHALL:
- load the buffer with {pc, 32'h0, adel=1}, set if_valid=1;
- enter FAULT;
- issue no memory request.
REQ-026 In FAULT, imem_req=0. redirect_valid or flush SHALL set pc to the supplied target, clear pend_valid and return to RUN next cycle.
REQ-027 flush SHALL override all other inputs in any state other than IDLE. On the next edge it SHALL:
- set pc=flush_target;
- clear if_valid, if_adel and pend_valid;
- set state RUN.
No fetch completes in a flush cycle: imem_req=0 while flush=1.
REQ-028 With id_ready=0 and if_valid=1, the buffer, pc and pend SHALL hold. Redirects SHALL still latch into pend.

Reset
REQ-029 While rst_n=0, without waiting for a clock edge:
- state=IDLE, pc=RESET_PC;
- if_valid=0, if_adel=0, if_pc=0, if_instr=0;
- pend_valid=0, pend_target=0;
- imem_req=0, imem_addr=RESET_PC.
REQ-030 Assertion of rst_n mid-fetch or mid-fault SHALL discard all in-flight and pending state.

Verification
REQ-031 Reset release, imem_ack=1, id_ready=1 -> imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; if_pc lags by one cycle.
REQ-032 Branch at 0x3004 accepted with redirect_target=0x3100 while 0x3008 completes the same cycle -> next imem_addr 0x3100. Repeat with imem_ack=0 that cycle -> 0x3008 completes next, then 0x3100.
REQ-033 id_ready=0 for 3 cycles with if_pc=0x3000 buffered -> imem_req=0; if_pc and imem_addr (0x3004) hold; fetching resumes the cycle id_ready=1.
REQ-034 Redirect to 0x3102 -> delay slot delivered, then if_adel=1, if_pc=0x3102, if_instr=0, imem_req=0. Redirect to 0x3200 in FAULT -> imem_addr=0x3200 next cycle.
REQ-035 flush with flush_target=0x4180 while pend_valid=1 and if_valid=1 -> if_valid=0, pend dropped, next imem_addr=0x4180.
REQ-036 rst_n low mid-run (between edges) -> if_valid=0 and imem_req=0 immediately; after release, refetch from 0x3000.
